// File: rtl/frame_stream_source.sv
// Avalon-ST pixel source: streams one WIDTH x HEIGHT frame in raster order
// from a 1-cycle-latency frame-buffer read port, framed with SOP/EOP.
// A 2-entry prefetch FIFO absorbs read latency so ready_in backpressure is
// honoured without losing or duplicating pixels.
module frame_stream_source #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic              valid_out,
    input  logic              ready_in
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  beat_cnt;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic              push;
    logic              pop;
    logic              last_beat;
    logic [2:0]        pending;

    // FIFO occupancy once in-flight reads land and this cycle's pop leaves;
    // pop implies a non-empty FIFO, so the subtraction cannot underflow.
    assign pending   = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign push      = inflight;
    assign valid_out = (fifo_count != 2'd0);
    assign pop       = valid_out && ready_in;
    assign last_beat = pop && (beat_cnt == CNT_W'(N - 1));
    assign busy      = (state == STREAM);

    // Issue reads while pixels remain and the FIFO has room for the result
    always_comb begin
        mem_rd   = (state == STREAM) && (rd_cnt < CNT_W'(N)) && (pending < 3'd2);
        mem_addr = mem_rd ? rd_cnt[ADDR_W-1:0] : '0;
    end

    // Output beat: FIFO head plus packet framing, forced to zero when idle
    always_comb begin
        data_out          = valid_out ? fifo_mem[rd_ptr] : '0;
        startofpacket_out = valid_out && (beat_cnt == '0);
        endofpacket_out   = valid_out && (beat_cnt == CNT_W'(N - 1));
    end

    // FIFO storage: capture read data on the edge after its read strobe
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Control: state, counters, FIFO pointers and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            beat_cnt   <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
            frame_done <= 1'b0;
        end else begin
            inflight   <= mem_rd;
            frame_done <= 1'b0;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= STREAM;
                        rd_cnt   <= '0;
                        beat_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (mem_rd) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (pop) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (last_beat) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        rd_cnt     <= '0;
                        beat_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source (4x4 frame, mem[i] = i + 10).
// Expected beats are queued when a frame is started and compared on each
// output handshake; a small occupancy model checks valid_out and read gating.
module tb_frame_stream_source;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic [7:0] data_out;
    logic       sop;
    logic       eop;
    logic       valid_out;
    logic       ready_in = 1'b1;

    int checks = 0;
    int failures = 0;

    beat_t q[$];
    int    cyc, exp_addr, beats, reads, first_valid, done_cyc;
    bit    done_seen, chain_req, chained;
    int    occ, inflight_m;
    bit    stall_prev;
    beat_t held;

    frame_stream_source #(.WIDTH(4), .HEIGHT(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .frame_done(frame_done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .data_out(data_out),
        .startofpacket_out(sop), .endofpacket_out(eop),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    // Frame buffer: synchronous read, 1-cycle latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= 8'(mem_addr) + 8'd10;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        q.delete();
        occ = 0;
        inflight_m = 0;
        stall_prev = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_rd"}, mem_rd, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_sop"}, sop, 0);
        chk({tag, "_eop"}, eop, 0);
        chk({tag, "_valid"}, valid_out, 0);
    endtask

    // One clock cycle: drive inputs at negedge, then check sampled outputs
    task automatic step(input logic r, input logic s);
        bit    pop;
        beat_t e;
        @(negedge clk);
        ready_in = r;
        start = s;
        #1;
        cyc++;
        pop = valid_out && r;
        chk("valid_vs_occupancy", valid_out, (occ != 0));
        if (stall_prev) begin
            chk("hold_valid", valid_out, 1);
            chk("hold_data", data_out, held.d);
            chk("hold_sop", sop, held.s);
            chk("hold_eop", eop, held.e);
        end
        if (pop) begin
            if (q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                e = q.pop_front();
                chk("beat_data", data_out, e.d);
                chk("beat_sop", sop, e.s);
                chk("beat_eop", eop, e.e);
            end
            beats++;
        end
        if (mem_rd) begin
            chk("rd_addr", mem_addr, exp_addr);
            chk("rd_addr_range", (exp_addr < 16), 1);
            chk("fifo_no_overflow", (occ + inflight_m - int'(pop) < 2), 1);
            exp_addr++;
            reads++;
        end
        if (valid_out && first_valid < 0) first_valid = cyc;
        if (frame_done) begin
            done_seen = 1;
            done_cyc = cyc;
            chk("done_after_eop", beats, 16);
            chk("busy_low_at_done", busy, 0);
            if (chain_req) begin
                start = 1'b1;
                chain_req = 0;
                chained = 1;
            end
        end
        occ = occ + inflight_m - int'(pop);
        inflight_m = int'(mem_rd);
        stall_prev = valid_out && !r;
        held = '{d: data_out, s: sop, e: eop};
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            1: return !(c >= 5 && c <= 9);
            2: return c[0];
            4: return (c >= 8);
            default: return 1'b1;
        endcase
    endfunction

    // Reset asserted during the current cycle; outputs checked the cycle after
    task automatic mid_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        reset_models();
    endtask

    // mode: 0 ready high, 1 stall 5..9, 2 toggle, 3 stray starts + chain,
    //       4 ready low before first beat, 5 reset in cycle 8
    task automatic run_frame(input int mode, input bit skip_start);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back('{d: 8'(i + 10), s: (i == 0), e: (i == 15)});
        exp_addr = 0; beats = 0; reads = 0;
        first_valid = -1; done_seen = 0; done_cyc = -1;
        chained = 0;
        chain_req = (mode == 3);
        if (skip_start) begin
            cyc = 0;
        end else begin
            cyc = -1;
            step(rdy(mode, 0), 1'b1);
        end
        for (int c = 1; c < 200 && !done_seen; c++) begin
            if (mode == 5 && c == 8) begin
                mid_reset();
                return;
            end
            step(rdy(mode, c), (mode == 3) && (c == 5 || c == 10));
            if (mode == 1 && c == 7) chk("stall_no_rd", mem_rd, 0);
            if (mode == 4 && c == 6) begin
                chk("prestall_valid", valid_out, 1);
                chk("prestall_sop", sop, 1);
            end
        end
        chk("frame_done_seen", done_seen, 1);
        chk("beat_count", beats, 16);
        chk("read_count", reads, 16);
        chk("queue_empty", q.size(), 0);
        if (mode == 0 || mode == 3 || mode == 4) chk("first_valid_cycle", first_valid, 3);
        if (mode == 0 || mode == 3) chk("frame_done_cycle", done_cyc, 19);
    endtask

    task automatic idle_cycle(input string tag);
        step(1'b1, 1'b0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_rd"}, mem_rd, 0);
    endtask

    initial begin
        reset_models();
        beats = 16;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("reset");

        run_frame(0, 0);
        idle_cycle("after_f1");

        run_frame(1, 0);
        idle_cycle("after_stall");

        run_frame(2, 0);
        idle_cycle("after_toggle");

        run_frame(3, 0);
        chk("chain_started", chained, 1);
        run_frame(0, 1);
        idle_cycle("after_chain");

        run_frame(5, 0);
        beats = 0;
        repeat (3) begin
            step(1'b1, 1'b0);
            chk("no_done_after_reset", frame_done, 0);
            chk("no_valid_after_reset", valid_out, 0);
        end
        run_frame(0, 0);

        run_frame(4, 0);
        idle_cycle("after_prestall");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
